// File: rtl/permute_burst_scheduler.sv
// Buffers bot entries in a FIFO and expands each entry's valid-permutation mask into
// one output beat per set bit, lowest bit first, while tracking batches in flight.
module permute_burst_scheduler #(
    parameter int  DATA_WIDTH         = 128,
    parameter int  MASK_WIDTH         = 6,
    parameter int  FIFO_DEPTH_LOG2    = 5,
    parameter int  SLOWDOWN_THRESHOLD = 24,
    parameter int  TAG_WIDTH          = 4,
    parameter int  MAX_BATCHES        = 8,
    localparam int SEL_WIDTH          = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1,
    localparam int BIF_WIDTH          = $clog2(MAX_BATCHES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeData,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [MASK_WIDTH-1:0] validMaskIn,
    input  logic                  batchDone,
    output logic                  slowDownInput,
    input  logic                  downstreamStall,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [SEL_WIDTH-1:0]  outSelect,
    output logic [TAG_WIDTH-1:0]  outBatchTag,
    output logic                  batchEnd,
    input  logic                  batchRetired,
    output logic [BIF_WIDTH-1:0]  batchesInFlight,
    output logic                  overflowError
);
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int USEDW_W = FIFO_DEPTH_LOG2 + 1;
    localparam int ENTRY_W = DATA_WIDTH + MASK_WIDTH + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [ENTRY_W-1:0]         mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [USEDW_W-1:0]         usedw_q, usedw_d;
    logic                       slow_q, ovf_q;

    logic [0:0]                 state_q, state_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [MASK_WIDTH-1:0]      rem_q, rem_d;
    logic                       done_q, done_d;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [BIF_WIDTH-1:0]       bif_q, bif_d;

    logic                       wr_qual, wr_en, fifo_full, fifo_empty;
    logic                       in_burst, emit, final_beat, batch_end, pop, retire;
    logic [MASK_WIDTH-1:0]      low_bit;
    logic [SEL_WIDTH-1:0]       sel;
    logic [ENTRY_W-1:0]         head;

    assign wr_qual    = writeData && ((|validMaskIn) || batchDone);
    assign fifo_full  = (usedw_q == USEDW_W'(DEPTH));
    assign fifo_empty = (usedw_q == '0);
    assign wr_en      = wr_qual && !fifo_full;
    assign head       = mem_q[rd_ptr_q];

    // Final beat means at most one bit left; an empty mask is a bare batch close.
    assign in_burst   = (state_q == ST_BURST);
    assign emit       = in_burst && !downstreamStall;
    assign low_bit    = rem_q & (~rem_q + MASK_WIDTH'(1));
    assign final_beat = ((rem_q & (rem_q - MASK_WIDTH'(1))) == '0);
    assign batch_end  = emit && final_beat && done_q;
    assign pop        = !fifo_empty && !downstreamStall
                        && (bif_q < BIF_WIDTH'(MAX_BATCHES))
                        && (!in_burst || final_beat);
    assign retire     = batchRetired && (bif_q != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel = '0;
        for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
            if (rem_q[i]) sel = SEL_WIDTH'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        done_d  = done_q;
        if (pop) begin
            data_d  = head[ENTRY_W-1 -: DATA_WIDTH];
            rem_d   = head[MASK_WIDTH:1];
            done_d  = head[0];
            state_d = ST_BURST;
        end else if (emit) begin
            rem_d = rem_q & ~low_bit;
            if (final_beat) state_d = ST_IDLE;
        end
    end

    always_comb begin
        usedw_d = usedw_q;
        case ({wr_en, pop})
            2'b10:   usedw_d = usedw_q + USEDW_W'(1);
            2'b01:   usedw_d = usedw_q - USEDW_W'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    always_comb begin
        bif_d = bif_q;
        case ({batch_end, retire})
            2'b10:   bif_d = bif_q + BIF_WIDTH'(1);
            2'b01:   bif_d = bif_q - BIF_WIDTH'(1);
            default: bif_d = bif_q;
        endcase
    end

    // NOTE: storage has no reset; clearing the pointers and usedw is what empties the FIFO.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {dataIn, validMaskIn, batchDone};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            slow_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            data_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            tag_q    <= '0;
            bif_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
            usedw_q <= usedw_d;
            slow_q  <= (usedw_q > USEDW_W'(SLOWDOWN_THRESHOLD));
            if (wr_qual && fifo_full) ovf_q <= 1'b1;
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            if (batch_end) tag_q <= tag_q + TAG_WIDTH'(1);
            bif_q   <= bif_d;
        end
    end

    assign slowDownInput   = slow_q;
    assign overflowError   = ovf_q;
    assign outValid        = emit && (rem_q != '0);
    assign outData         = data_q;
    assign outSelect       = sel;
    assign outBatchTag     = tag_q;
    assign batchEnd        = batch_end;
    assign batchesInFlight = bif_q;

endmodule
